// File: rtl/sodor5_sched_pkg.sv
// Shared types, encodings and word-formation helpers for the Sodor 5-stage
// constrained-random instruction scheduler.
package sodor5_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [11:0] MASK_SRAI = 12'h41F;
    localparam logic [11:0] MASK_SLLI = 12'h01F;

    // An all-zero Galois LFSR never leaves zero, so substitute 1.
    function automatic logic [31:0] lfsr_fix_seed(input logic [31:0] seed);
        return (seed == '0) ? 32'h0000_0001 : seed;
    endfunction

    function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic logic [31:0] make_word(input logic [31:0] s);
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  op;
        imm = s[31:20];
        f3  = s[14:12];
        if (s[0]) begin
            op = OP_IMM;
            // Shift-immediate forms only carry a shamt (plus the SRAI bit).
            if (f3 == 3'd5) begin
                imm = imm & MASK_SRAI;
            end else if (f3 == 3'd1) begin
                imm = imm & MASK_SLLI;
            end
        end else begin
            op = OP_LOAD;
            f3 = f3 & 3'b100;
        end
        return {imm, s[19:15], f3, s[11:7], op};
    endfunction

endpackage

// File: rtl/sodor5_lfsr32.sv
// 32-bit right-shift Galois LFSR with synchronous seed load and step enable.
module sodor5_lfsr32
    import sodor5_sched_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = lfsr_fix_seed(seed);
        end else if (step) begin
            state_d = lfsr_advance(state_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= lfsr_fix_seed(RESET_SEED);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sodor5_instr_sched.sv
// Sequenced instruction source: NOP flush, random I-type/load run, NOP drain,
// delivered over a valid/ready handshake so stalls never alter the stream.
module sodor5_instr_sched
    import sodor5_sched_pkg::*;
#(
    parameter logic [31:0] SEED         = 32'h0000_0057,
    parameter int unsigned NUM_INSTR    = 100,
    parameter int unsigned NOP_CYCLES   = 3,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] issued_cnt
);

    localparam logic [16:0] NUM_N   = 17'(NUM_INSTR);
    localparam logic [16:0] NOP_N   = 17'(NOP_CYCLES);
    localparam logic [16:0] DRAIN_N = 17'(DRAIN_CYCLES);

    // Zero-length phases are skipped by resolving each phase's successor up front.
    localparam sched_state_e POST_RUN   = (DRAIN_CYCLES != 0) ? ST_DRAIN : ST_DONE;
    localparam sched_state_e POST_FLUSH = (NUM_INSTR != 0)    ? ST_RUN   : POST_RUN;
    localparam sched_state_e POST_START = (NOP_CYCLES != 0)   ? ST_FLUSH : POST_FLUSH;

    sched_state_e state_q, state_d, tgt;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  phase_q, phase_d;
    logic         enter, hs;
    logic         lfsr_load, lfsr_step;
    logic [31:0]  lfsr_s;

    sodor5_lfsr32 #(.RESET_SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .seed  (SEED),
        .step  (lfsr_step),
        .state (lfsr_s)
    );

    assign hs = valid_q & instr_ready;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        enter     = 1'b0;
        tgt       = ST_IDLE;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    enter     = 1'b1;
                    tgt       = POST_START;
                end
            end
            ST_FLUSH: begin
                if (hs) begin
                    if (({1'b0, phase_q} + 17'd1) == NOP_N) begin
                        enter = 1'b1;
                        tgt   = POST_FLUSH;
                    end else begin
                        phase_d = phase_q + 16'd1;
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    lfsr_step = 1'b1;
                    cnt_d     = cnt_q + 16'd1;
                    if (({1'b0, cnt_q} + 17'd1) == NUM_N) begin
                        enter = 1'b1;
                        tgt   = POST_RUN;
                    end else begin
                        instr_d = make_word(lfsr_advance(lfsr_s));
                    end
                end
            end
            ST_DRAIN: begin
                if (hs) begin
                    if (({1'b0, phase_q} + 17'd1) == DRAIN_N) begin
                        enter = 1'b1;
                        tgt   = ST_DONE;
                    end else begin
                        phase_d = phase_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The first RUN word must come from the seed being loaded this same edge.
        if (enter) begin
            state_d = tgt;
            phase_d = '0;
            case (tgt)
                ST_RUN: begin
                    instr_d = make_word(lfsr_load ? lfsr_fix_seed(SEED) : lfsr_s);
                    valid_d = 1'b1;
                end
                ST_DONE: begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    instr_d = NOP;
                    valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= NOP;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign issued_cnt  = cnt_q;
    assign busy        = (state_q == ST_FLUSH) || (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: doc/sodor5_instr_sched.md
# sodor5_instr_sched

Constrained-random instruction scheduler for the Sodor 5-stage lockstep verification harness. Replaces free-running per-cycle instruction generation with a sequenced stream: NOP flush, a fixed-length run of random I-type ALU / load instructions, then a NOP drain so the pipeline retires. Delivery uses a valid/ready handshake, so the stream is identical regardless of core stalls. The block sits in front of the shared instruction port that drives both the model and the RTL core.

## Interface
- `SEED`: default 32'h0000_0057. LFSR seed, reloaded on every start. Zero is replaced by 32'h1.
- `NUM_INSTR`: default 100. Random instructions per run, 0..65535.
- `NOP_CYCLES`: default 3. Flush NOPs before the run.
- `DRAIN_CYCLES`: default 4. Drain NOPs after the run.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sequence. Sampled in IDLE and DONE only.
- `instr` out 32: instruction word (registered).
- `instr_valid` out 1: `instr` is valid (registered).
- `instr_ready` in 1: consumer accepts `instr` this cycle.
- `busy` out 1: state is FLUSH, RUN or DRAIN.
- `done` out 1: sequence complete. Held until the next start.
- `issued_cnt` out 16: RUN handshakes in the current sequence.

## Operation
- A handshake occurs when `instr_valid && instr_ready` at a posedge.
- While `instr_valid=1` and `instr_ready=0`, `instr` holds stable.
- States: IDLE, FLUSH, RUN, DRAIN, DONE.
  - IDLE/DONE: on `start`, load the LFSR with SEED, clear counters and `done`, then go to FLUSH. If NOP_CYCLES=0, go to RUN; if NUM_INSTR is also 0, go to DRAIN. If DRAIN_CYCLES is also 0, go straight to DONE.
  - FLUSH: present NOP 32'h00000013. After NOP_CYCLES handshakes, go to RUN (or DRAIN if NUM_INSTR=0).
  - RUN: present the random word built from the current LFSR state `s`. Each handshake advances the LFSR one step and increments `issued_cnt`. After NUM_INSTR handshakes, go to DRAIN.
  - DRAIN: present NOP. After DRAIN_CYCLES handshakes, go to DONE with `instr_valid=0`.
- `start` in FLUSH, RUN or DRAIN is ignored.
- LFSR: 32-bit Galois, right-shift. Next state = `s[0] ? (s>>1)^32'h80200003 : s>>1`.
- Word construction:
  - If `s[0]=1` (I-type ALU): imm=`s[31:20]`, rs1=`s[19:15]`, funct3=`s[14:12]`, rd=`s[11:7]`, opcode 7'b0010011.
    - funct3=5: imm &= 12'h41F.
    - funct3=1: imm &= 12'h01F.
  - If `s[0]=0` (load): same fields, but funct3=`s[14:12] & 3'b100` (LB or LBU), opcode 7'b0000011.

## Timing
- Reset values:
  - state IDLE
  - `instr`=32'h00000013
  - `instr_valid`=0, `busy`=0, `done`=0, `issued_cnt`=0
  - LFSR=SEED (0 is replaced by 1)
- Reset mid-sequence returns to IDLE immediately, with all outputs at their reset values.
- `start` seen at edge N gives `instr_valid=1` with the first word at edge N+1.
- Every transition and word update is registered on the handshake edge. The next word appears the cycle after acceptance, so the stream runs back-to-back at 1 instruction/cycle when `instr_ready` is held high.
- After the last RUN handshake, the next cycle presents a NOP. This holds when NUM_INSTR=1 as well.
- `done` rises on the edge after the final DRAIN handshake. `busy` falls on the same edge.
- `start` asserted on the same edge that enters DONE is ignored. `start` is honored from DONE on subsequent cycles.
- `issued_cnt` is 16-bit unsigned. It never exceeds NUM_INSTR, so there is no wrap.

## Structure
- `sodor5_sched_pkg` holds:
  - state enum
  - NOP constant 32'h00000013
  - opcodes OP_IMM 7'b0010011 and OP_LOAD 7'b0000011
  - LFSR polynomial 32'h80200003
  - masks 12'h41F and 12'h01F
- Sub-module `sodor5_lfsr32` has ports `clk`, `reset`, `load`, `seed`, `step` and `state`. It owns the zero-seed substitution.
- Word formation is a combinational function in the package. The top module holds the FSM and counters.

## Test plan
- Defaults, `instr_ready`=1, pulse `start`:
  - 3 NOPs, then 100 random words, then 4 NOPs.
  - `done`=1 exactly 108 cycles after the start edge (1 cycle of start latency plus 107 handshakes).
  - `issued_cnt`=100.
- SEED=32'hFFF0_5001, NOP_CYCLES=0: first RUN word is 32'h41F05013 (SRAI mask applied).
- SEED=32'h0020_6000, NOP_CYCLES=0: first word is 32'h00204003 (funct3 6 masked to LBU).
- SEED=0, NOP_CYCLES=0: first word is 32'h00000013 (LFSR forced to 1).
- Random `instr_ready` stalls at about 50%:
  - `instr` is stable during every stall.
  - The accepted stream is bit-identical to the no-stall run with the same SEED.
- Sequence interruptions:
  - Assert `reset` mid-RUN: next cycle shows `instr_valid`=0, `issued_cnt`=0, state IDLE.
  - Pulse `start` during DRAIN: it is ignored.
  - Run two back-to-back sequences: identical streams.
